usb_ls_tx: RTL

Low-speed (1.5 Mbit/s) USB serial transmitter that converts a byte stream from the SIE packet logic into line states on D+/D-. It adds SYNC, applies bit stuffing and NRZI encoding, and terminates each packet with EOP. It drives the `d_o`/`d_en` pair that the top level connects to the GPIO D+/D- tristate. It is the transmit counterpart of the SIE's line receiver (NRZI decode, unstuff, EOP detect) inside `usb_device_controller`.

---
 rtl/usb_ls_tx_if.sv | 16 +
 rtl/usb_ls_tx.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/usb_ls_tx_if.sv
// usb_ls_tx_if
//   Byte-stream handshake between the SIE packet logic and the low-speed
//   USB transmitter.
//   tx_data  : byte to send, LSB first
//   tx_valid : tx_data is valid
//   tx_last  : tx_data is the final byte of the packet
//   tx_ready : byte accepted on a cycle with tx_valid && tx_ready
interface usb_ls_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, output tx_last, input tx_ready);
  modport slave  (input tx_data, input tx_valid, input tx_last, output tx_ready);
endinterface

// File: rtl/usb_ls_tx.sv
// usb_ls_tx
//   Low-speed (1.5 Mbit/s) USB serial transmitter. Turns a byte stream into
//   D+/D- line states: SYNC, bit stuffing, NRZI, EOP.
//   clk    : system clock (24 MHz)
//   reset  : asynchronous, active-low
//   tx     : byte handshake (slave side)
//   d_o    : line state, bit1 = D-, bit0 = D+ (J = 10, K = 01, SE0 = 00)
//   d_en   : output enable for the D+/D- pads
//   busy   : packet in progress
//   tx_err : one-cycle pulse when a packet is aborted on underrun
//
// state | meaning
// IDLE  | pads released, line J, waiting for the first byte
// SYNC  | sending the 0x80 sync pattern
// DATA  | sending data bytes from the shift register
// EOP   | SE0, SE0, J, then release the pads
module usb_ls_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  usb_ls_tx_if.slave  tx,
  output logic [1:0]  d_o,
  output logic        d_en,
  output logic        busy,
  output logic        tx_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SYNC = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_EOP  = 2'd3;

  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] TMR_LOAD = TW'(CLKS_PER_BIT - 1);

  logic [1:0]    state;
  logic [TW-1:0] tmr;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic [7:0]    hold;
  logic          hold_full;
  logic          last_taken;
  logic [2:0]    ones;
  logic [1:0]    eop_cnt;
  logic          accept;

  // NRZI: a 0 toggles J/K, a 1 holds the line.
  function automatic logic [1:0] nrzi(input logic [1:0] line, input logic b);
    return b ? line : {line[0], line[1]};
  endfunction

  // Gated with reset so the handshake is closed while reset is held.
  assign tx.tx_ready = reset && (state != ST_EOP) && !hold_full && !last_taken;
  assign accept      = tx.tx_valid && tx.tx_ready;
  assign busy        = (state != ST_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      tmr        <= TMR_LOAD;
      bit_idx    <= 3'd0;
      shift      <= 8'h00;
      hold       <= 8'h00;
      hold_full  <= 1'b0;
      last_taken <= 1'b0;
      ones       <= 3'd0;
      eop_cnt    <= 2'd0;
      d_o        <= LINE_J;
      d_en       <= 1'b0;
      tx_err     <= 1'b0;
    end else begin
      tx_err <= 1'b0;

      if (accept) begin
        hold      <= tx.tx_data;
        hold_full <= 1'b1;
        if (tx.tx_last) last_taken <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (accept) begin
            // First SYNC bit (a 0) goes out right away: J -> K.
            state   <= ST_SYNC;
            d_en    <= 1'b1;
            d_o     <= LINE_K;
            tmr     <= TMR_LOAD;
            bit_idx <= 3'd0;
            shift   <= 8'h80;
            ones    <= 3'd0;
          end
        end

        ST_SYNC, ST_DATA: begin
          if (tmr != '0) begin
            tmr <= tmr - TW'(1);
          end else begin
            tmr <= TMR_LOAD;
            if (ones == 3'd6) begin
              // Stuffed 0: toggles the line, bit_idx holds so no data is consumed.
              d_o  <= nrzi(d_o, 1'b0);
              ones <= 3'd0;
            end else if (bit_idx != 3'd7) begin
              bit_idx <= bit_idx + 3'd1;
              d_o     <= nrzi(d_o, shift[bit_idx + 3'd1]);
              ones    <= shift[bit_idx + 3'd1] ? ones + 3'd1 : 3'd0;
            end else if (hold_full) begin
              state     <= ST_DATA;
              shift     <= hold;
              hold_full <= 1'b0;
              bit_idx   <= 3'd0;
              d_o       <= nrzi(d_o, hold[0]);
              ones      <= hold[0] ? ones + 3'd1 : 3'd0;
            end else begin
              // Either the last byte has gone out, or the feeder underran.
              // A byte accepted on this very edge is too late and is dropped.
              if (!last_taken) tx_err <= 1'b1;
              state     <= ST_EOP;
              hold_full <= 1'b0;
              d_o       <= LINE_SE0;
              eop_cnt   <= 2'd0;
            end
          end
        end

        default: begin // ST_EOP
          if (tmr != '0) begin
            tmr <= tmr - TW'(1);
          end else begin
            tmr <= TMR_LOAD;
            case (eop_cnt)
              2'd0: eop_cnt <= 2'd1;
              2'd1: begin
                eop_cnt <= 2'd2;
                d_o     <= LINE_J;
              end
              default: begin
                state      <= ST_IDLE;
                d_en       <= 1'b0;
                hold_full  <= 1'b0;
                last_taken <= 1'b0;
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule
